pmem_responder: RTL and testbench

Physical-memory responder for the cache hierarchy. It answers the L2 cache controller's pmem_read/pmem_write line requests with a fixed, parameterised latency and a single-cycle pmem_resp pulse. It holds whole cache lines in an internal synthesizable array. It is the memory end of the L2 miss path and is used in simulation and FPGA builds in place of an external DRAM controller.

---
 rtl/pmem_responder.sv | 134 +++++++++++++
 tb/tb_pmem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory responder for the L2 miss path.
// Holds whole cache lines in an internal array and answers one line request at a time.
module pmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_BITS   = 256,
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_BITS-1:0]  pmem_wdata,
  output logic [LINE_BITS-1:0]  pmem_rdata,
  output logic                  pmem_resp,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  localparam int OFF_W = $clog2(LINE_BITS / 8);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  // Handshake: a request is accepted when pmem_read or pmem_write is high in IDLE;
  // the requester holds it until pmem_resp, which pulses for exactly one cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

  logic [IDX_W-1:0]     in_idx;
  logic                 req_held;
  logic                 addr_unused;

  assign in_idx      = pmem_address[OFF_W +: IDX_W];
  assign addr_unused = ^{pmem_address[ADDR_WIDTH-1:OFF_W+IDX_W], pmem_address[OFF_W-1:0]};
  assign req_held    = op_wr_q ? pmem_write : pmem_read;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Line store: cleared by reset, written only at the end of a write's RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_LINES; i++) mem_q[i] <= '0;
    end else if (state_q == S_RESP && op_wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pmem_read || pmem_write) begin
          if (LATENCY == 1) state_d = S_RESP;
          else              state_d = S_WAIT;
        end
      end
      S_WAIT:  if (cnt_q == 8'd1) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (pmem_read || pmem_write) begin
          op_wr_d = pmem_write;
          idx_d   = in_idx;
          wdata_d = pmem_wdata;
          cnt_d   = LAT_M1;
          if (pmem_read && pmem_write) err_d = 1'b1;
          // With single-cycle latency RESP follows accept directly, so read the live index.
          if (LATENCY == 1 && !pmem_write) rdata_d = mem_q[in_idx];
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (!req_held) err_d = 1'b1;
        if (cnt_q == 8'd1 && !op_wr_q) rdata_d = mem_q[idx_q];
      end
      S_RESP: begin
        if (!req_held) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pmem_resp  = (state_q == S_RESP);
    busy       = (state_q != S_IDLE);
    err        = err_q;
    pmem_rdata = rdata_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: a LATENCY=8 instance and a LATENCY=1 instance,
// with a reference line model and an expected-read-data queue checked on each pmem_resp.
module tb_pmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         a_read = 1'b0, a_write = 1'b0;
  logic [31:0]  a_addr = '0;
  logic [255:0] a_wdata = '0;
  logic [255:0] a_rdata;
  logic         a_resp, a_busy, a_err;
  logic [1:0]   a_state;

  logic         b_read = 1'b0, b_write = 1'b0;
  logic [31:0]  b_addr = '0;
  logic [255:0] b_wdata = '0;
  logic [255:0] b_rdata;
  logic         b_resp, b_busy, b_err;
  logic [1:0]   b_state;

  pmem_responder #(.LATENCY(8)) dut_a (
    .clk(clk), .rst(rst), .pmem_read(a_read), .pmem_write(a_write),
    .pmem_address(a_addr), .pmem_wdata(a_wdata), .pmem_rdata(a_rdata),
    .pmem_resp(a_resp), .busy(a_busy), .err(a_err), .dbg_state(a_state)
  );

  pmem_responder #(.LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .pmem_read(b_read), .pmem_write(b_write),
    .pmem_address(b_addr), .pmem_wdata(b_wdata), .pmem_rdata(b_rdata),
    .pmem_resp(b_resp), .busy(b_busy), .err(b_err), .dbg_state(b_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];
  logic [255:0] model [2][64];
  bit           exp_err [2];
  int           last_resp = 0;

  localparam logic [255:0] P1 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] P2 = {8{32'h1234_5678}};
  localparam logic [255:0] P3 = {8{32'hCAFE_F00D}};
  localparam logic [255:0] P4 = {8{32'hA5A5_5A5A}};
  localparam logic [255:0] P5 = {8{32'h0BAD_F00D}};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit use1, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [255:0] wd);
    if (use1) begin
      b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd;
    end else begin
      a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) model[d][i] = '0;
      exp_err[d] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  // One request on the chosen instance: drive it in an IDLE cycle, hold it until
  // pmem_resp (or drop it at cycle drop_at), then check latency, busy, data and err.
  task automatic txn(input string tag, input bit use1, input bit rd, input bit wr,
                     input logic [31:0] addr, input logic [255:0] wd, input int drop_at);
    int lat, n, busy_n;
    bit got, rsp, bsy;
    logic [5:0] idx;
    logic [255:0] exp_rd;
    lat = use1 ? 1 : 8;
    idx = addr[10:5];
    @(negedge clk);
    chk({tag, "_idle_busy"}, use1 ? b_busy : a_busy, 0);
    drive(use1, rd, wr, addr, wd);
    if (rd && !wr) exp_q.push_back(model[use1][idx]);
    if (rd && wr) exp_err[use1] = 1'b1;
    got = 1'b0;
    busy_n = 0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == drop_at) begin
        drive(use1, 0, 0, addr, wd);
        exp_err[use1] = 1'b1;
      end
      rsp = use1 ? b_resp : a_resp;
      bsy = use1 ? b_busy : a_busy;
      if (bsy) busy_n++;
      if (rsp) begin
        got = 1'b1;
        last_resp = cyc;
        chk({tag, "_latency"}, n, lat);
      end
    end
    chk({tag, "_resp_seen"}, got, 1);
    if (got) begin
      chk({tag, "_busy_cycles"}, busy_n, lat);
      if (rd && !wr) begin
        exp_rd = exp_q.pop_front();
        chk({tag, "_rdata"}, use1 ? b_rdata : a_rdata, exp_rd);
      end
      if (wr) model[use1][idx] = wd;
    end
    chk({tag, "_err"}, use1 ? b_err : a_err, exp_err[use1]);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
  endtask

  initial begin
    int t1, t2, resp_n;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_resp",  a_resp,  0);
    chk("rst_busy",  a_busy,  0);
    chk("rst_err",   a_err,   0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_state", a_state, 0);
    chk("rst_b_resp", b_resp, 0);

    // Plain read after reset
    txn("rd40", 0, 1, 0, 32'h0000_0040, '0, 0);
    idle_cycle();

    // Offset and alias bits ignored
    txn("wr60", 0, 0, 1, 32'h0000_0060, P1, 0);
    idle_cycle();
    txn("rd7f", 0, 1, 0, 32'h0000_007F, '0, 0);
    idle_cycle();
    txn("rd860", 0, 1, 0, 32'h0000_0860, '0, 0);
    idle_cycle();

    // Writeback then fill, back to back
    txn("wb_a", 0, 0, 1, 32'h0000_0100, P2, 0);
    t1 = last_resp;
    txn("fill_b", 0, 1, 0, 32'h0000_0060, '0, 0);
    t2 = last_resp;
    chk("b2b_spacing", t2 - t1, 9);
    idle_cycle();
    txn("rd_a", 0, 1, 0, 32'h0000_0100, '0, 0);
    idle_cycle();

    // Read and write together: write wins, err sticks
    txn("both", 0, 1, 1, 32'h0000_0020, P3, 0);
    idle_cycle();
    txn("rd20", 0, 1, 0, 32'h0000_0020, '0, 0);
    idle_cycle();

    // Reset clears err and the array
    do_reset();
    chk("rst2_err", a_err, 0);
    txn("rd60_z", 0, 1, 0, 32'h0000_0060, '0, 0);
    idle_cycle();

    // Request dropped mid-wait
    txn("drop", 0, 1, 0, 32'h0000_0100, '0, 3);
    idle_cycle();

    // Reset in the middle of a write
    do_reset();
    @(negedge clk);
    drive(0, 0, 1, 32'h0000_00A0, P4);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    resp_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_resp) resp_n++;
    end
    chk("midrst_noresp", resp_n, 0);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_err", a_err, 0);
    txn("rda0_z", 0, 1, 0, 32'h0000_00A0, '0, 0);
    idle_cycle();

    // Single-cycle latency instance
    txn("l1_rd", 1, 1, 0, 32'h0000_0040, '0, 0);
    idle_cycle();
    txn("l1_wr", 1, 0, 1, 32'h0000_0040, P5, 0);
    idle_cycle();
    txn("l1_rd1", 1, 1, 0, 32'h0000_0040, '0, 0);
    t1 = last_resp;
    txn("l1_rd2", 1, 1, 0, 32'h0000_0860, '0, 0);
    t2 = last_resp;
    chk("l1_spacing", t2 - t1, 2);
    idle_cycle();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
